// File: rtl/gbc_cart_bus_controller.sv
// Routes system-bus accesses to a physical Game Boy pak or to a mapper; the target is chosen once after reset.
// Define GBC_PAK_POWERDOWN_EN to drive all Pak outputs except PakReset to 0 while the mapper is in use.
module gbc_cart_bus_controller #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int PAK_WAIT       = 3,
  parameter int DETECT_CYCLES  = 4,
  parameter int DETECT_TIMEOUT = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ClkEn,
  input  logic              BusAccess,
  input  logic              BusWrite,
  input  logic [ADDR_W-1:0] BusAddress,
  input  logic [DATA_W-1:0] BusDToTarget,
  output logic [DATA_W-1:0] BusDToInitiator,
  output logic              BusReady,
  output logic              BusDataReady,
  output logic              MapAccess,
  output logic              MapWrite,
  output logic [ADDR_W-1:0] MapAddress,
  output logic [DATA_W-1:0] MapDToTarget,
  input  logic [DATA_W-1:0] MapDToInitiator,
  input  logic              MapDataReady,
  output logic              PakCS,
  output logic              PakRead,
  output logic              PakWrite,
  output logic [ADDR_W-1:0] PakAddress,
  output logic [DATA_W-1:0] PakDToPak,
  input  logic [DATA_W-1:0] PakDFromPak,
  output logic              PakReset,
  input  logic              PakDetect,
  input  logic              ForceMapper,
  output logic              UseCartridge,
  output logic              PakLost
);

  localparam int CNT_W  = $clog2(DETECT_TIMEOUT + 1);
  localparam int WAIT_W = (PAK_WAIT > 1) ? $clog2(PAK_WAIT) : 1;

  typedef enum logic [2:0] {
    S_DETECT,
    S_IDLE,
    S_MAP_WAIT,
    S_PAK_STROBE,
    S_PAK_HOLD
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_det_cnt;
  logic [CNT_W-1:0]  r_to_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_write;
  logic              r_use_cart;
  logic              r_pak_lost;
  logic              r_bus_ready;
  logic              r_bus_dr;
  logic              r_map_access;
  logic              r_pak_cs;
  logic              r_pak_rd;
  logic              r_pak_wr;
  logic              r_pak_reset;

  logic [CNT_W-1:0]  w_det_next;
  logic [CNT_W-1:0]  w_to_next;

  assign w_det_next = PakDetect ? (r_det_cnt + 1'b1) : '0;
  assign w_to_next  = r_to_cnt + 1'b1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= S_DETECT;
      r_det_cnt    <= '0;
      r_to_cnt     <= '0;
      r_wait_cnt   <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_write      <= 1'b0;
      r_use_cart   <= 1'b0;
      r_pak_lost   <= 1'b0;
      r_bus_ready  <= 1'b0;
      r_bus_dr     <= 1'b0;
      r_map_access <= 1'b0;
      r_pak_cs     <= 1'b0;
      r_pak_rd     <= 1'b0;
      r_pak_wr     <= 1'b0;
      r_pak_reset  <= 1'b1;
    end else begin
      // Completion and mapper request are single-clock pulses even when ClkEn is sparse
      r_bus_dr     <= 1'b0;
      r_map_access <= 1'b0;
      if (ClkEn && r_use_cart && (r_state != S_DETECT) && !PakDetect) begin
        r_pak_lost <= 1'b1;
      end
      case (r_state)
        S_DETECT: begin
          if (ClkEn) begin
            r_det_cnt <= w_det_next;
            r_to_cnt  <= w_to_next;
            if (ForceMapper || (w_det_next == CNT_W'(DETECT_CYCLES)) ||
                (w_to_next == CNT_W'(DETECT_TIMEOUT))) begin
              r_use_cart  <= !ForceMapper && (w_det_next == CNT_W'(DETECT_CYCLES));
              r_state     <= S_IDLE;
              r_bus_ready <= 1'b1;
              r_pak_reset <= 1'b0;
            end
          end
        end
        S_IDLE: begin
          if (ClkEn && BusAccess) begin
            r_addr      <= BusAddress;
            r_wdata     <= BusDToTarget;
            r_write     <= BusWrite;
            r_bus_ready <= 1'b0;
            if (r_use_cart) begin
              r_state    <= S_PAK_STROBE;
              r_wait_cnt <= '0;
              r_pak_cs   <= 1'b1;
              r_pak_rd   <= !BusWrite;
              r_pak_wr   <= BusWrite;
            end else begin
              r_state      <= S_MAP_WAIT;
              r_map_access <= 1'b1;
            end
          end
        end
        S_MAP_WAIT: begin
          if (MapDataReady) begin
            r_rdata     <= MapDToInitiator;
            r_bus_dr    <= 1'b1;
            r_bus_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_PAK_STROBE: begin
          if (ClkEn) begin
            if (r_wait_cnt == WAIT_W'(PAK_WAIT - 1)) begin
              if (!r_write) begin
                r_rdata <= PakDFromPak;
              end
              r_bus_dr <= 1'b1;
              r_pak_cs <= 1'b0;
              r_pak_rd <= 1'b0;
              r_pak_wr <= 1'b0;
              r_state  <= S_PAK_HOLD;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
        end
        S_PAK_HOLD: begin
          if (ClkEn) begin
            r_bus_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_DETECT;
        end
      endcase
    end
  end

  assign BusDToInitiator = r_rdata;
  assign BusReady        = r_bus_ready;
  assign BusDataReady    = r_bus_dr;
  assign MapAccess       = r_map_access;
  assign MapWrite        = r_write;
  assign MapAddress      = r_addr;
  assign MapDToTarget    = r_wdata;
  assign PakReset        = r_pak_reset;
  assign UseCartridge    = r_use_cart;
  assign PakLost         = r_pak_lost;

`ifdef GBC_PAK_POWERDOWN_EN
  assign PakCS      = r_pak_cs & r_use_cart;
  assign PakRead    = r_pak_rd & r_use_cart;
  assign PakWrite   = r_pak_wr & r_use_cart;
  assign PakAddress = r_use_cart ? r_addr : '0;
  assign PakDToPak  = r_use_cart ? r_wdata : '0;
`else
  assign PakCS      = r_pak_cs;
  assign PakRead    = r_pak_rd;
  assign PakWrite   = r_pak_wr;
  assign PakAddress = r_addr;
  assign PakDToPak  = r_wdata;
`endif

endmodule

// File: tb/tb_gbc_cart_bus_controller.sv
// Self-checking bench for gbc_cart_bus_controller: randomized accesses against a transaction-level model.
module tb_gbc_cart_bus_controller;
  localparam int PAK_WAIT       = 3;
  localparam int DETECT_CYCLES  = 4;
  localparam int DETECT_TIMEOUT = 64;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ClkEn = 1'b1;
  logic        BusAccess = 1'b0;
  logic        BusWrite = 1'b0;
  logic [15:0] BusAddress = 16'h0000;
  logic [7:0]  BusDToTarget = 8'h00;
  logic [7:0]  BusDToInitiator;
  logic        BusReady, BusDataReady;
  logic        MapAccess, MapWrite;
  logic [15:0] MapAddress;
  logic [7:0]  MapDToTarget;
  logic [7:0]  MapDToInitiator = 8'h00;
  logic        MapDataReady = 1'b0;
  logic        PakCS, PakRead, PakWrite, PakReset;
  logic [15:0] PakAddress;
  logic [7:0]  PakDToPak;
  logic [7:0]  PakDFromPak = 8'h00;
  logic        PakDetect = 1'b0;
  logic        ForceMapper = 1'b0;
  logic        UseCartridge, PakLost;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_rd = 8'h00;
  logic        exp_use = 1'b0;

  gbc_cart_bus_controller #(
    .ADDR_W(16), .DATA_W(8), .PAK_WAIT(PAK_WAIT),
    .DETECT_CYCLES(DETECT_CYCLES), .DETECT_TIMEOUT(DETECT_TIMEOUT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .ClkEn(ClkEn),
    .BusAccess(BusAccess), .BusWrite(BusWrite), .BusAddress(BusAddress),
    .BusDToTarget(BusDToTarget), .BusDToInitiator(BusDToInitiator),
    .BusReady(BusReady), .BusDataReady(BusDataReady),
    .MapAccess(MapAccess), .MapWrite(MapWrite), .MapAddress(MapAddress),
    .MapDToTarget(MapDToTarget), .MapDToInitiator(MapDToInitiator), .MapDataReady(MapDataReady),
    .PakCS(PakCS), .PakRead(PakRead), .PakWrite(PakWrite), .PakAddress(PakAddress),
    .PakDToPak(PakDToPak), .PakDFromPak(PakDFromPak), .PakReset(PakReset), .PakDetect(PakDetect),
    .ForceMapper(ForceMapper), .UseCartridge(UseCartridge), .PakLost(PakLost)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; ClkEn = 1'b1; BusAccess = 1'b0; MapDataReady = 1'b0; ForceMapper = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    exp_rd = 8'h00;
    exp_use = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; ClkEn = 1'b1;
    tick(); tick();
    n_vec++;
    if ({BusReady, BusDataReady, UseCartridge, PakLost, PakReset, MapAccess, PakCS, PakRead, PakWrite, BusDToInitiator}
        !== {9'b000010000, 8'h00}) begin
      n_err++;
      $display("FAIL reset_state got=%h want=%h",
               {BusReady, BusDataReady, UseCartridge, PakLost, PakReset, MapAccess, PakCS, PakRead, PakWrite, BusDToInitiator},
               {9'b000010000, 8'h00});
    end
    Reset = 1'b0;
  endtask

  // mode 0: PakDetect=1, 1: PakDetect=0, 2: 1,1,1,0 pattern, 3: random PakDetect and ClkEn
  task automatic test_detect(input int mode);
    int run, ec;
    logic pd, en, exited;
    do_reset();
    run = 0; ec = 0; exited = 1'b0;
    for (int k = 1; k <= 400 && !exited; k++) begin
      en = (mode == 3) ? 1'($urandom % 2) : 1'b1;
      case (mode)
        0: pd = 1'b1;
        1: pd = 1'b0;
        2: pd = ((ec % 4) != 3);
        default: pd = (($urandom % 4) != 0);
      endcase
      ClkEn = en; PakDetect = pd;
      tick();
      if (en) begin
        ec++;
        run = pd ? run + 1 : 0;
        if (run == DETECT_CYCLES) begin exited = 1'b1; exp_use = 1'b1; end
        else if (ec == DETECT_TIMEOUT) begin exited = 1'b1; exp_use = 1'b0; end
      end
      n_vec++;
      if ({BusReady, UseCartridge, PakReset} !== (exited ? {1'b1, exp_use, 1'b0} : 3'b001)) begin
        n_err++;
        $display("FAIL detect_m%0d clk%0d got=%b want=%b", mode, k, {BusReady, UseCartridge, PakReset},
                 (exited ? {1'b1, exp_use, 1'b0} : 3'b001));
      end
    end
    PakDetect = exp_use;
    ClkEn = 1'b1;
  endtask

  task automatic test_force_mapper();
    do_reset();
    PakDetect = 1'b1; ForceMapper = 1'b1; ClkEn = 1'b1;
    tick();
    ForceMapper = 1'b0;
    exp_use = 1'b0;
    n_vec++;
    if ({BusReady, UseCartridge, PakReset} !== 3'b100) begin
      n_err++;
      $display("FAIL force_mapper got=%b want=100", {BusReady, UseCartridge, PakReset});
    end
  endtask

  task automatic map_access(input logic [15:0] a, input logic [7:0] d, input logic w, input int lat,
                            input logic rand_en, input logic fix, input logic [7:0] fdata);
    logic [15:0] exp_pa;
    logic [7:0]  exp_pd;
`ifdef GBC_PAK_POWERDOWN_EN
    exp_pa = 16'h0000; exp_pd = 8'h00;
`else
    exp_pa = a; exp_pd = d;
`endif
    BusAccess = 1'b1; BusWrite = w; BusAddress = a; BusDToTarget = d; ClkEn = 1'b1;
    tick();
    for (int j = 0; j <= lat; j++) begin
      BusAccess = 1'($urandom % 2); BusWrite = 1'($urandom % 2);
      BusAddress = 16'($urandom); BusDToTarget = 8'($urandom);
      if (rand_en) ClkEn = 1'($urandom % 2);
      MapDToInitiator = fix ? fdata : 8'($urandom);
      MapDataReady = (j == lat);
      n_vec++;
      if ({MapAccess, MapWrite, MapAddress, MapDToTarget, BusReady, BusDataReady, PakCS}
          !== {(j == 0), w, a, d, 1'b0, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL map_wait j%0d got=%h want=%h", j,
                 {MapAccess, MapWrite, MapAddress, MapDToTarget, BusReady, BusDataReady, PakCS},
                 {(j == 0), w, a, d, 1'b0, 1'b0, 1'b0});
      end
      if (j == lat) exp_rd = MapDToInitiator;
      tick();
    end
    MapDataReady = 1'b0; BusAccess = 1'b0;
    n_vec++;
    if ({BusDataReady, BusReady, BusDToInitiator, PakAddress, PakDToPak} !== {1'b1, 1'b1, exp_rd, exp_pa, exp_pd}) begin
      n_err++;
      $display("FAIL map_done got=%h want=%h", {BusDataReady, BusReady, BusDToInitiator, PakAddress, PakDToPak},
               {1'b1, 1'b1, exp_rd, exp_pa, exp_pd});
    end
    tick();
    n_vec++;
    if ({BusDataReady, BusReady, MapAccess} !== 3'b010) begin
      n_err++;
      $display("FAIL map_after got=%b want=010", {BusDataReady, BusReady, MapAccess});
    end
  endtask

  // mode 0: ClkEn always high, 1: alternate, 2: random
  task automatic pak_access(input logic [15:0] a, input logic [7:0] d, input logic w, input int mode,
                            input logic drop, input logic fix, input logic [7:0] fdata);
    int en_seen, cyc;
    logic en, first, done;
    BusAccess = 1'b1; BusWrite = w; BusAddress = a; BusDToTarget = d; ClkEn = 1'b1;
    tick();
    en_seen = 0; cyc = 0;
    while (en_seen < PAK_WAIT) begin
      cyc++;
      if (cyc > 200) begin
        n_vec++; n_err++;
        $display("FAIL pak_strobe_bound got=%0d want<=200", cyc);
        break;
      end
      en = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom % 2);
      ClkEn = en;
      PakDFromPak = fix ? fdata : 8'($urandom);
      BusAccess = 1'($urandom % 2); BusWrite = 1'($urandom % 2);
      BusAddress = 16'($urandom); BusDToTarget = 8'($urandom);
      if (drop && cyc == 2) PakDetect = 1'b0;
      n_vec++;
      if ({PakCS, PakRead, PakWrite, PakAddress, PakDToPak, BusReady, BusDataReady}
          !== {1'b1, !w, w, a, d, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL pak_strobe c%0d got=%h want=%h", cyc,
                 {PakCS, PakRead, PakWrite, PakAddress, PakDToPak, BusReady, BusDataReady},
                 {1'b1, !w, w, a, d, 1'b0, 1'b0});
      end
      if (en) begin
        en_seen++;
        if (en_seen == PAK_WAIT && !w) exp_rd = PakDFromPak;
      end
      tick();
    end
    first = 1'b1; done = 1'b0;
    while (!done) begin
      cyc++;
      en = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom % 2);
      if (cyc > 400) en = 1'b1;
      ClkEn = en;
      n_vec++;
      if ({PakCS, PakRead, PakWrite, PakAddress, PakDToPak, BusReady, BusDataReady, BusDToInitiator}
          !== {3'b000, a, d, 1'b0, first, exp_rd}) begin
        n_err++;
        $display("FAIL pak_hold c%0d got=%h want=%h", cyc,
                 {PakCS, PakRead, PakWrite, PakAddress, PakDToPak, BusReady, BusDataReady, BusDToInitiator},
                 {3'b000, a, d, 1'b0, first, exp_rd});
      end
      first = 1'b0; done = en;
      tick();
    end
    BusAccess = 1'b0; ClkEn = 1'b1;
    n_vec++;
    if ({BusReady, BusDataReady, PakCS, BusDToInitiator} !== {3'b100, exp_rd}) begin
      n_err++;
      $display("FAIL pak_after got=%h want=%h", {BusReady, BusDataReady, PakCS, BusDToInitiator}, {3'b100, exp_rd});
    end
  endtask

  task automatic test_idle_gating();
    ClkEn = 1'b0; BusAccess = 1'b1; BusAddress = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if ({BusReady, MapAccess, PakCS} !== 3'b100) begin
        n_err++;
        $display("FAIL idle_gating got=%b want=100", {BusReady, MapAccess, PakCS});
      end
    end
    BusAccess = 1'b0; ClkEn = 1'b1;
  endtask

  task automatic test_pak_lost();
    n_vec++;
    if (PakLost !== 1'b0) begin
      n_err++;
      $display("FAIL paklost_pre got=%b want=0", PakLost);
    end
    pak_access(16'h2000, 8'h00, 1'b0, 0, 1'b1, 1'b1, 8'h77);
    tick();
    PakDetect = 1'b1;
    tick();
    n_vec++;
    if ({PakLost, UseCartridge} !== 2'b11) begin
      n_err++;
      $display("FAIL paklost_sticky got=%b want=11", {PakLost, UseCartridge});
    end
  endtask

  task automatic test_reset_mid_strobe();
    BusAccess = 1'b1; BusWrite = 1'b0; BusAddress = 16'h0150; ClkEn = 1'b1;
    tick();
    BusAccess = 1'b0;
    tick();
    n_vec++;
    if (PakCS !== 1'b1) begin
      n_err++;
      $display("FAIL midstrobe_pre got=%b want=1", PakCS);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0; PakDetect = 1'b0; exp_rd = 8'h00;
    n_vec++;
    if ({PakCS, PakRead, PakWrite, BusDataReady, BusReady, PakReset, UseCartridge, MapAccess, BusDToInitiator}
        !== {8'b00000100, 8'h00}) begin
      n_err++;
      $display("FAIL midstrobe_reset got=%h want=%h",
               {PakCS, PakRead, PakWrite, BusDataReady, BusReady, PakReset, UseCartridge, MapAccess, BusDToInitiator},
               {8'b00000100, 8'h00});
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if ({BusDataReady, BusReady, PakReset} !== 3'b001) begin
        n_err++;
        $display("FAIL midstrobe_after got=%b want=001", {BusDataReady, BusReady, PakReset});
      end
    end
  endtask

  initial begin
    test_reset();
    // pak path: fixed read 0x0150 -> 0xC3, alternate-ClkEn write, random traffic
    test_detect(0);
    pak_access(16'h0150, 8'h00, 1'b0, 0, 1'b0, 1'b1, 8'hC3);
    pak_access(16'hA000, 8'h12, 1'b1, 1, 1'b0, 1'b0, 8'h00);
    test_idle_gating();
    for (int i = 0; i < 20; i++)
      pak_access(16'($urandom), 8'($urandom), 1'($urandom % 2), i % 3, 1'b0, 1'b0, 8'h00);
    test_pak_lost();
    test_reset_mid_strobe();
    // mapper path
    test_detect(1);
    map_access(16'h4000, 8'h00, 1'b0, 2, 1'b0, 1'b1, 8'h5A);
    for (int i = 0; i < 20; i++)
      map_access(16'($urandom), 8'($urandom), 1'($urandom % 2), int'($urandom_range(0, 4)), 1'b1, 1'b0, 8'h00);
    test_detect(2);
    test_force_mapper();
    map_access(16'h1234, 8'hAB, 1'b1, 1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      test_detect(3);
      if (exp_use) pak_access(16'($urandom), 8'($urandom), 1'($urandom % 2), 2, 1'b0, 1'b0, 8'h00);
      else map_access(16'($urandom), 8'($urandom), 1'($urandom % 2), 1, 1'b1, 1'b0, 8'h00);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gbc_cart_bus_controller.md
GBC_CART_BUS_CONTROLLER -- requirements
Module: gbc_cart_bus_controller

Interface
REQ-001 SHALL have parameters: ADDR_W (default 16), address width; DATA_W (default 8), data width; PAK_WAIT (default 3, min 1), ClkEn cycles a physical-pak strobe is held; DETECT_CYCLES (default 4, min 1), consecutive ClkEn samples of PakDetect=1 that select the cartridge; DETECT_TIMEOUT (default 64, greater than DETECT_CYCLES), ClkEn cycles before falling back to the mapper.
REQ-002 SHALL have ports, clock and reset first: Clk in 1, system clock; Reset in 1, synchronous active-high reset; ClkEn in 1, clock enable qualifying all state advances.
REQ-003 SHALL have system-bus ports: BusAccess in 1, request; BusWrite in 1, 1=write; BusAddress in ADDR_W; BusDToTarget in DATA_W, write data; BusDToInitiator out DATA_W, read data; BusReady out 1, can accept a request; BusDataReady out 1, one-cycle completion pulse.
REQ-004 SHALL have mapper ports: MapAccess out 1; MapWrite out 1; MapAddress out ADDR_W; MapDToTarget out DATA_W; MapDToInitiator in DATA_W; MapDataReady in 1, completion.
REQ-005 SHALL have pak ports: PakCS out 1; PakRead out 1; PakWrite out 1; PakAddress out ADDR_W; PakDToPak out DATA_W; PakDFromPak in DATA_W; PakReset out 1; PakDetect in 1, cartridge present.
REQ-006 SHALL have status ports: ForceMapper in 1, disables pak selection; UseCartridge out 1, pak selected; PakLost out 1, sticky pak-removal flag.

Function
REQ-007 SHALL implement states DETECT, IDLE, MAP_WAIT, PAK_STROBE, PAK_HOLD; all transitions except Reset and MapDataReady handling occur only on cycles with ClkEn=1.
REQ-008 DETECT: PakReset=1, BusReady=0; detect counter increments on PakDetect=1 and clears on PakDetect=0; a timeout counter increments every ClkEn cycle.
REQ-009 DETECT exit: ForceMapper=1 -> UseCartridge=0, IDLE; detect counter reaches DETECT_CYCLES -> UseCartridge=1, IDLE; timeout counter reaches DETECT_TIMEOUT first -> UseCartridge=0, IDLE; detect wins if both occur in the same cycle.
REQ-010 UseCartridge SHALL remain fixed from leaving DETECT until the next Reset.
REQ-011 IDLE: BusReady=1; a cycle with BusAccess=1 latches address, write data and BusWrite, drives BusReady=0 from the next cycle, and enters MAP_WAIT (UseCartridge=0) or PAK_STROBE (UseCartridge=1).
REQ-012 MAP_WAIT: MapAccess=1 for exactly the first cycle, with Map outputs carrying the latched values; on MapDataReady=1, BusDToInitiator<=MapDToInitiator, BusDataReady=1 for one cycle, -> IDLE.
REQ-013 PAK_STROBE: PakCS=1, PakRead=!write, PakWrite=write for PAK_WAIT ClkEn cycles; on the last cycle a read latches PakDFromPak into BusDToInitiator; -> PAK_HOLD.
REQ-014 PAK_HOLD: strobes deasserted for one ClkEn cycle, BusDataReady=1 for one cycle, -> IDLE; PakAddress/PakDToPak remain held through PAK_HOLD.
REQ-015 BusAccess outside IDLE SHALL be ignored; no queueing.
REQ-016 PakDetect=0 while UseCartridge=1 and not in DETECT SHALL set PakLost=1; an in-flight access still completes with the sampled data.
REQ-017 Read latency, ClkEn held high: mapper = 1 + mapper latency + 1 cycles; pak = PAK_WAIT + 2 cycles from the accept cycle to the BusDataReady cycle inclusive.

Reset
REQ-018 Reset=1 SHALL force DETECT, clear both counters, and set UseCartridge=0, PakLost=0, BusReady=0, BusDataReady=0, BusDToInitiator=0, Map/Pak strobes=0 and PakReset=1, aborting any in-flight access without a BusDataReady pulse.

Configuration
REQ-019 With GBC_PAK_POWERDOWN_EN defined, all Pak outputs except PakReset SHALL be driven 0 whenever UseCartridge=0.
REQ-020 Without GBC_PAK_POWERDOWN_EN, PakAddress and PakDToPak SHALL mirror the latched bus values regardless of UseCartridge; strobes still obey REQ-013/014.

Verification
REQ-021 PakDetect=1 constant, read 0x0150, PakDFromPak=0xC3 -> UseCartridge=1 after 4 ClkEn cycles; BusDataReady with 0xC3 exactly 5 cycles after accept.
REQ-022 PakDetect=0 -> UseCartridge=0 after 64 ClkEn cycles; mapper read 0x4000, MapDataReady 2 cycles after MapAccess returns 0x5A -> BusDToInitiator=0x5A, one-cycle BusDataReady.
REQ-023 PakDetect toggles 1,1,1,0 repeatedly -> timeout to mapper; ForceMapper=1 with PakDetect=1 -> UseCartridge=0 on the first ClkEn cycle.
REQ-024 ClkEn high on alternate cycles, pak write 0xA000=0x12 -> PakWrite held 3 ClkEn cycles (6 clocks), PakCS cleared for PAK_HOLD.
REQ-025 Reset asserted mid-PAK_STROBE -> all strobes 0 next cycle, no BusDataReady, state DETECT; PakDetect dropped during an access -> PakLost=1 and access completes.
